// File: rtl/windower_frame_arbiter_if.sv
// rtl/windower_frame_arbiter_if.sv - source-side and windower-side handshake bundle for windower_frame_arbiter
interface windower_frame_arbiter_if #(
    parameter int NO_CH      = 8,
    parameter int THROUGHPUT = 1,
    parameter int NO_SRC     = 4
);
    localparam int LW = THROUGHPUT * NO_CH;
    localparam int SW = (NO_SRC > 1) ? $clog2(NO_SRC) : 1;

    logic [NO_SRC-1:0]    req_vld;
    logic [NO_SRC*LW-1:0] req_data;
    logic [NO_SRC-1:0]    req_rdy;
    logic                 win_vld_in;
    logic [LW-1:0]        win_data_in;
    logic [SW-1:0]        src_id;
    logic                 frame_start;
    logic                 frame_end;
    logic                 busy;

    // master: the sources plus whoever watches the windower feed
    modport master (
        output req_vld, req_data,
        input  req_rdy, win_vld_in, win_data_in, src_id, frame_start, frame_end, busy
    );

    modport slave (
        input  req_vld, req_data,
        output req_rdy, win_vld_in, win_data_in, src_id, frame_start, frame_end, busy
    );
endinterface

// File: rtl/windower_frame_arbiter.sv
// rtl/windower_frame_arbiter.sv - whole-frame round-robin scheduler feeding one windower from NO_SRC streams
// Optional WFA_FRAME_GAP_EN adds GAP_CYCLES idle cycles after every frame.
module windower_frame_arbiter #(
    parameter int NO_CH         = 8,
    parameter int LOG2_IMG_SIZE = 7,
    parameter int THROUGHPUT    = 1,
    parameter int NO_SRC        = 4,
    parameter int GAP_CYCLES    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    windower_frame_arbiter_if.slave  bus
);
    localparam int BEATS = (1 << LOG2_IMG_SIZE) / THROUGHPUT;
    localparam int CW    = LOG2_IMG_SIZE + 1;
    localparam int LW    = THROUGHPUT * NO_CH;
    localparam int SW    = (NO_SRC > 1) ? $clog2(NO_SRC) : 1;

    localparam logic [CW-1:0]     LAST_BEAT = CW'(BEATS - 1);
    localparam logic [SW-1:0]     LAST_SRC  = SW'(NO_SRC - 1);
    localparam logic [NO_SRC-1:0] RDY_ONE   = NO_SRC'(1);

`ifdef WFA_FRAME_GAP_EN
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;
    logic [GW-1:0] gap_cnt;
`else
    typedef enum logic {IDLE, STREAM} state_t;
`endif

    state_t        state;
    logic [SW-1:0] grant;
    logic [SW-1:0] last_grant;
    logic [SW-1:0] pick;
    logic [SW-1:0] cand;
    logic [CW-1:0] beat_cnt;
    logic          xfer;
    logic [LW-1:0] grant_slice;

    // Walk the ring from farthest to nearest so the source just after last_grant wins.
    always_comb begin
        pick = last_grant;
        cand = last_grant;
        for (int i = NO_SRC; i >= 1; i--) begin
            cand = SW'((int'(last_grant) + i) % NO_SRC);
            if (bus.req_vld[cand]) begin
                pick = cand;
            end
        end
    end

    assign xfer        = (state == STREAM) && bus.req_vld[grant];
    assign grant_slice = bus.req_data[int'(grant)*LW +: LW];
    assign bus.req_rdy = (state == STREAM) ? (RDY_ONE << grant) : '0;
    assign bus.busy    = (state != IDLE);
    // grant only moves at arbitration, so it doubles as the frame tag for the windower output
    assign bus.src_id  = grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            grant           <= '0;
            last_grant      <= LAST_SRC;
            beat_cnt        <= '0;
            bus.win_vld_in  <= 1'b0;
            bus.win_data_in <= '0;
            bus.frame_start <= 1'b0;
            bus.frame_end   <= 1'b0;
`ifdef WFA_FRAME_GAP_EN
            gap_cnt         <= '0;
`endif
        end else begin
            bus.win_vld_in  <= xfer;
            bus.frame_start <= xfer && (beat_cnt == '0);
            bus.frame_end   <= xfer && (beat_cnt == LAST_BEAT);
            if (xfer) begin
                bus.win_data_in <= grant_slice;
            end

            case (state)
                IDLE: begin
                    if (|bus.req_vld) begin
                        grant      <= pick;
                        last_grant <= pick;
                        beat_cnt   <= '0;
                        state      <= STREAM;
                    end
                end
                STREAM: begin
                    // a low req_vld from the owner just stalls; the lock is never revoked
                    if (xfer) begin
                        if (beat_cnt == LAST_BEAT) begin
                            beat_cnt <= '0;
`ifdef WFA_FRAME_GAP_EN
                            gap_cnt  <= '0;
                            state    <= GAP;
`else
                            state    <= IDLE;
`endif
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
`ifdef WFA_FRAME_GAP_EN
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule
